// File: rtl/alu_pkg.sv
// Shared types and constants for the ALU operand sequencer and its bench.
package alu_pkg;

  typedef enum logic [2:0] {
    S_A    = 3'b000,
    S_B    = 3'b001,
    S_OP   = 3'b010,
    S_EXEC = 3'b011,
    S_OUT  = 3'b100
  } seq_state_e;

  localparam logic [1:0] OP_ADD = 2'b00;
  localparam logic [1:0] OP_SUB = 2'b01;
  localparam logic [1:0] OP_AND = 2'b10;
  localparam logic [1:0] OP_OR  = 2'b11;

  localparam int unsigned FLAG_N = 3;
  localparam int unsigned FLAG_Z = 2;
  localparam int unsigned FLAG_C = 1;
  localparam int unsigned FLAG_V = 0;

  localparam int unsigned FLAGS_W = 4;
  localparam int unsigned STATE_W = 3;

endpackage

// File: rtl/btn_sync_edge.sv
// Two-flop synchronizer plus delay flop; emits one pulse per rising edge of a raw button.
module btn_sync_edge (
  input  logic clk,
  input  logic rst_n,
  input  logic btn_raw,
  output logic pulse
);

  logic sync1_q;
  logic sync2_q;
  logic sync3_q;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sync1_q <= 1'b0;
      sync2_q <= 1'b0;
      sync3_q <= 1'b0;
    end else begin
      sync1_q <= btn_raw;
      sync2_q <= sync1_q;
      sync3_q <= sync2_q;
    end
  end

  // Decoded from two flops of the same clock domain, so safe to use combinationally.
  assign pulse = sync2_q & ~sync3_q;

endmodule

// File: rtl/alu_operand_sequencer.sv
// Collects A, B and op code from switches on button presses, holds them on the ALU,
// registers the ALU result and hands it downstream over valid/ready.
module alu_operand_sequencer
  import alu_pkg::*;
#(
  parameter int unsigned BITS  = 5,
  parameter int unsigned CNT_W = 8
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic [BITS-1:0]    data_in,
  input  logic [1:0]         op_in,
  input  logic               load_btn,
  input  logic               abort,
  output logic [BITS-1:0]    alu_a,
  output logic [BITS-1:0]    alu_b,
  output logic [1:0]         alu_ctrl,
  input  logic [BITS-1:0]    alu_result,
  input  logic [3:0]         alu_flags,
  output logic               res_valid,
  input  logic               res_ready,
  output logic [BITS-1:0]    res_data,
  output logic [3:0]         res_flags,
  output logic               busy,
  output logic [2:0]         state_dbg,
  output logic [CNT_W-1:0]   op_count
);

  logic load_pulse;

  btn_sync_edge u_load_sync (
    .clk     (clk),
    .rst_n   (rst_n),
    .btn_raw (load_btn),
    .pulse   (load_pulse)
  );

  seq_state_e          state_q, state_d;
  logic [BITS-1:0]     alu_a_q, alu_a_d;
  logic [BITS-1:0]     alu_b_q, alu_b_d;
  logic [1:0]          alu_ctrl_q, alu_ctrl_d;
  logic [BITS-1:0]     res_data_q, res_data_d;
  logic [FLAGS_W-1:0]  res_flags_q, res_flags_d;
  logic                res_valid_q, res_valid_d;
  logic [CNT_W-1:0]    op_count_q, op_count_d;
  logic                busy_q, busy_d;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= S_A;
      alu_a_q     <= '0;
      alu_b_q     <= '0;
      alu_ctrl_q  <= '0;
      res_data_q  <= '0;
      res_flags_q <= '0;
      res_valid_q <= 1'b0;
      op_count_q  <= '0;
      busy_q      <= 1'b0;
    end else begin
      state_q     <= state_d;
      alu_a_q     <= alu_a_d;
      alu_b_q     <= alu_b_d;
      alu_ctrl_q  <= alu_ctrl_d;
      res_data_q  <= res_data_d;
      res_flags_q <= res_flags_d;
      res_valid_q <= res_valid_d;
      op_count_q  <= op_count_d;
      busy_q      <= busy_d;
    end
  end

  // Abort overrides everything; otherwise one step of the load/exec/output sequence.
  always_comb begin
    state_d     = state_q;
    alu_a_d     = alu_a_q;
    alu_b_d     = alu_b_q;
    alu_ctrl_d  = alu_ctrl_q;
    res_data_d  = res_data_q;
    res_flags_d = res_flags_q;
    res_valid_d = res_valid_q;
    op_count_d  = op_count_q;

    if (abort) begin
      state_d     = S_A;
      res_valid_d = 1'b0;
      alu_a_d     = '0;
      alu_b_d     = '0;
      alu_ctrl_d  = '0;
    end else begin
      case (state_q)
        S_A: begin
          if (load_pulse) begin
            alu_a_d = data_in;
            state_d = S_B;
          end
        end
        S_B: begin
          if (load_pulse) begin
            alu_b_d = data_in;
            state_d = S_OP;
          end
        end
        S_OP: begin
          if (load_pulse) begin
            alu_ctrl_d = op_in;
            state_d    = S_EXEC;
          end
        end
        S_EXEC: begin
          res_data_d  = alu_result;
          res_flags_d = alu_flags;
          res_valid_d = 1'b1;
          state_d     = S_OUT;
        end
        S_OUT: begin
          if (res_valid_q && res_ready) begin
            res_valid_d = 1'b0;
            op_count_d  = op_count_q + CNT_W'(1);
            state_d     = S_A;
          end
        end
        default: state_d = S_A;
      endcase
    end

    busy_d = (state_d == S_EXEC) || (state_d == S_OUT);
  end

  assign alu_a     = alu_a_q;
  assign alu_b     = alu_b_q;
  assign alu_ctrl  = alu_ctrl_q;
  assign res_data  = res_data_q;
  assign res_flags = res_flags_q;
  assign res_valid = res_valid_q;
  assign op_count  = op_count_q;
  assign busy      = busy_q;
  assign state_dbg = STATE_W'(state_q);

endmodule

// File: tb/tb_alu_operand_sequencer.sv
// Self-checking bench: behavioural sequencer model compared every cycle, plus directed literal checks.
module tb_alu_operand_sequencer;
  import alu_pkg::*;

  localparam int unsigned BITS  = 5;
  localparam int unsigned CNT_W = 8;

  logic             clk = 1'b0;
  logic             rst_n = 1'b0;
  logic [BITS-1:0]  data_in = '0;
  logic [1:0]       op_in = '0;
  logic             load_btn = 1'b0;
  logic             abort = 1'b0;
  logic [BITS-1:0]  alu_a, alu_b;
  logic [1:0]       alu_ctrl;
  logic [BITS-1:0]  alu_result;
  logic [3:0]       alu_flags;
  logic             res_valid;
  logic             res_ready = 1'b0;
  logic [BITS-1:0]  res_data;
  logic [3:0]       res_flags;
  logic             busy;
  logic [2:0]       state_dbg;
  logic [CNT_W-1:0] op_count;

  int n_chk = 0;
  int n_fail = 0;
  bit chk_en = 1'b0;

  alu_operand_sequencer #(.BITS(BITS), .CNT_W(CNT_W)) dut (
    .clk(clk), .rst_n(rst_n), .data_in(data_in), .op_in(op_in),
    .load_btn(load_btn), .abort(abort), .alu_a(alu_a), .alu_b(alu_b),
    .alu_ctrl(alu_ctrl), .alu_result(alu_result), .alu_flags(alu_flags),
    .res_valid(res_valid), .res_ready(res_ready), .res_data(res_data),
    .res_flags(res_flags), .busy(busy), .state_dbg(state_dbg), .op_count(op_count)
  );

  always #5 clk = ~clk;

  // Reference ALU: returns {flags, result}
  function automatic logic [BITS+3:0] alu_fn(logic [BITS-1:0] a, logic [BITS-1:0] b, logic [1:0] op);
    logic [BITS:0]   s;
    logic [BITS-1:0] r;
    logic c, v;
    c = 1'b0;
    v = 1'b0;
    case (op)
      OP_ADD: begin
        s = {1'b0, a} + {1'b0, b};
        r = s[BITS-1:0]; c = s[BITS];
        v = (a[BITS-1] == b[BITS-1]) && (r[BITS-1] != a[BITS-1]);
      end
      OP_SUB: begin
        s = {1'b0, a} + {1'b0, ~b} + (BITS+1)'(1);
        r = s[BITS-1:0]; c = s[BITS];
        v = (a[BITS-1] != b[BITS-1]) && (r[BITS-1] != a[BITS-1]);
      end
      OP_AND:  r = a & b;
      default: r = a | b;
    endcase
    return {r[BITS-1], (r == '0), c, v, r};
  endfunction

  always_comb {alu_flags, alu_result} = alu_fn(alu_a, alu_b, alu_ctrl);

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
    end
  endtask

  // Behavioural model: phase numbers follow the spec's state encoding
  int              m_phase;
  logic [BITS-1:0] m_a, m_b, m_res;
  logic [1:0]      m_ctrl;
  logic [3:0]      m_flags;
  logic            m_valid;
  int              m_cnt;
  logic [2:0]      btn_hist;  // btn samples from 1, 2 and 3 edges ago

  always @(posedge clk or negedge rst_n) begin
    logic press;
    if (!rst_n) begin
      m_phase = 0; m_a = '0; m_b = '0; m_ctrl = '0; m_res = '0; m_flags = '0;
      m_valid = 1'b0; m_cnt = 0; btn_hist = '0;
    end else begin
      press = btn_hist[1] && !btn_hist[2];
      btn_hist = {btn_hist[1:0], load_btn};
      if (abort) begin
        m_phase = 0; m_valid = 1'b0; m_a = '0; m_b = '0; m_ctrl = '0;
      end else begin
        case (m_phase)
          0: if (press) begin m_a = data_in; m_phase = 1; end
          1: if (press) begin m_b = data_in; m_phase = 2; end
          2: if (press) begin m_ctrl = op_in; m_phase = 3; end
          3: begin {m_flags, m_res} = alu_fn(m_a, m_b, m_ctrl); m_valid = 1'b1; m_phase = 4; end
          default: if (res_ready) begin m_valid = 1'b0; m_cnt = (m_cnt + 1) % 256; m_phase = 0; end
        endcase
      end
    end
  end

  // Per-cycle comparison against the model, away from the active edge
  always @(negedge clk) begin
    if (chk_en && rst_n) begin
      chk("state", 32'(state_dbg), 32'(m_phase));
      chk("alu_a", 32'(alu_a), 32'(m_a));
      chk("alu_b", 32'(alu_b), 32'(m_b));
      chk("alu_ctrl", 32'(alu_ctrl), 32'(m_ctrl));
      chk("res_valid", 32'(res_valid), 32'(m_valid));
      chk("res_data", 32'(res_data), 32'(m_res));
      chk("res_flags", 32'(res_flags), 32'(m_flags));
      chk("busy", 32'(busy), 32'(m_phase == 3 || m_phase == 4));
      chk("op_count", 32'(op_count), 32'(m_cnt));
    end
  end

  task automatic press(input logic [BITS-1:0] d, input logic [1:0] o, input int hold);
    data_in = d; op_in = o; load_btn = 1'b1;
    repeat (hold) @(negedge clk);
    load_btn = 1'b0;
    repeat (4) @(negedge clk);
  endtask

  task automatic wait_state(input int st, input int budget, input string name);
    int i;
    for (i = 0; i < budget; i++) begin
      if (32'(state_dbg) == st) break;
      @(negedge clk);
    end
    if (i == budget) begin
      n_chk++; n_fail++;
      $display("FAIL %s: timeout waiting for state %0d, state=%0d", name, st, state_dbg);
    end
  endtask

  task automatic do_op(input logic [BITS-1:0] a, input logic [BITS-1:0] b, input logic [1:0] o);
    res_ready = 1'b1;
    press(a, 0, 2);
    press(b, 0, 2);
    press(0, o, 2);
    wait_state(0, 20, "op_done");
  endtask

  initial begin
    int n;
    logic [BITS-1:0] hd;
    logic [3:0] hf;
    logic [CNT_W-1:0] cnt_save;

    repeat (2) @(negedge clk);
    chk("reset_state", 32'(state_dbg), 0);
    chk("reset_valid", 32'(res_valid), 0);
    chk("reset_count", 32'(op_count), 0);
    rst_n = 1'b1;
    chk_en = 1'b1;
    @(negedge clk);

    // Basic add with latency measurement on the op-code press
    res_ready = 1'b0;
    press(7, 0, 2);
    press(3, 0, 2);
    op_in = OP_ADD; load_btn = 1'b1; n = 0;
    for (int i = 1; i <= 10; i++) begin
      @(negedge clk);
      if (i == 3) load_btn = 1'b0;
      if (res_valid) begin n = i; break; end
    end
    load_btn = 1'b0;
    n_chk++;
    if (n < 4 || n > 5) begin
      n_fail++;
      $display("FAIL latency: got %0d edges expected 4..5", n);
    end
    chk("add_a", 32'(alu_a), 7);
    chk("add_b", 32'(alu_b), 3);
    chk("add_ctrl", 32'(alu_ctrl), 0);
    chk("add_res", 32'(res_data), 10);
    chk("add_flags", 32'(res_flags), 0);
    res_ready = 1'b1;
    @(negedge clk);
    chk("add_count", 32'(op_count), 1);
    chk("add_state", 32'(state_dbg), 0);

    // Subtract to zero
    do_op(9, 9, OP_SUB);
    chk("sub_res", 32'(res_data), 0);
    chk("sub_z", 32'(res_flags[FLAG_Z]), 1);

    // Backpressure with ignored presses in S_OUT
    res_ready = 1'b0;
    press(12, 0, 2); press(6, 0, 2); press(0, OP_AND, 2);
    wait_state(4, 10, "bp_reach_out");
    hd = res_data; hf = res_flags;
    chk("bp_and", 32'(hd), 32'(12 & 6));
    press(1, 0, 2);
    press(2, 0, 2);
    repeat (2) @(negedge clk);
    chk("bp_state", 32'(state_dbg), 4);
    chk("bp_valid", 32'(res_valid), 1);
    chk("bp_data", 32'(res_data), 32'(hd));
    chk("bp_flags", 32'(res_flags), 32'(hf));
    res_ready = 1'b1;
    @(negedge clk);
    chk("bp_done", 32'(state_dbg), 0);
    press(21, 0, 2);
    chk("bp_next_a", 32'(alu_a), 21);
    chk("bp_next_state", 32'(state_dbg), 1);

    // Long press gives a single advance
    abort = 1'b1; @(negedge clk); abort = 1'b0;
    press(17, 0, 50);
    chk("long_state", 32'(state_dbg), 1);
    chk("long_a", 32'(alu_a), 17);

    // Abort in S_OP, then in S_OUT together with ready
    press(4, 0, 2);
    chk("pre_abort_op", 32'(state_dbg), 2);
    cnt_save = op_count;
    abort = 1'b1; @(negedge clk); abort = 1'b0;
    chk("abort_op_state", 32'(state_dbg), 0);
    chk("abort_op_a", 32'(alu_a), 0);
    chk("abort_op_b", 32'(alu_b), 0);
    res_ready = 1'b0;
    press(5, 0, 2); press(6, 0, 2); press(0, OP_OR, 2);
    wait_state(4, 10, "abort_reach_out");
    abort = 1'b1; res_ready = 1'b1; @(negedge clk); abort = 1'b0;
    chk("abort_out_state", 32'(state_dbg), 0);
    chk("abort_out_valid", 32'(res_valid), 0);
    chk("abort_out_ctrl", 32'(alu_ctrl), 0);
    chk("abort_out_count", 32'(op_count), 32'(cnt_save));

    // Random operations with random backpressure and occasional aborts
    for (int k = 0; k < 40; k++) begin
      res_ready = 1'b0;
      press(BITS'($urandom), 0, 1 + $urandom_range(0, 3));
      press(BITS'($urandom), 0, 1 + $urandom_range(0, 3));
      press(0, 2'($urandom), 1 + $urandom_range(0, 3));
      for (int j = 0; j < 6; j++) begin
        res_ready = 1'($urandom);
        abort = ($urandom_range(0, 19) == 0);
        @(negedge clk);
      end
      abort = 1'b0;
      res_ready = 1'b1;
      wait_state(0, 10, "rand_done");
    end

    // Counter wrap, then async reset while holding a result in S_OUT
    while (op_count != 8'd255) do_op(BITS'($urandom), BITS'($urandom), 2'($urandom));
    chk("pre_wrap", 32'(op_count), 255);
    do_op(1, 2, OP_ADD);
    chk("wrap", 32'(op_count), 0);
    res_ready = 1'b0;
    press(3, 0, 2); press(4, 0, 2); press(0, OP_ADD, 2);
    chk("rst_pre_state", 32'(state_dbg), 4);
    #2 rst_n = 1'b0;
    #1;
    chk("rst_state", 32'(state_dbg), 0);
    chk("rst_valid", 32'(res_valid), 0);
    chk("rst_data", 32'(res_data), 0);
    chk("rst_flags", 32'(res_flags), 0);
    chk("rst_a", 32'(alu_a), 0);
    chk("rst_b", 32'(alu_b), 0);
    chk("rst_ctrl", 32'(alu_ctrl), 0);
    chk("rst_busy", 32'(busy), 0);
    #1 rst_n = 1'b1;
    repeat (3) @(negedge clk);
    chk("post_rst_state", 32'(state_dbg), 0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

endmodule
